// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one read/write memory channel between NUM_CONSUMERS requesters.
// Optional wait-state watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int NUM_CONSUMERS  = 4,
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready,
  output logic                               timeout_err
);

  localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    READ_WAITING  = 2'd1,
    WRITE_WAITING = 2'd2,
    RELAYING      = 2'd3
  } state_e;

  // Handshake rule on both sides: a transfer completes on the cycle valid and
  // ready are both high; the requester holds valid (and its address/data)
  // stable until it sees ready, then drops valid.

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic                 is_read_q, is_read_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic [DATA_BITS-1:0] rdata_q [NUM_CONSUMERS];
  logic [DATA_BITS-1:0] rdata_d [NUM_CONSUMERS];

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;
`endif

  logic             arb_found;
  logic             arb_read;
  logic [IDX_W-1:0] arb_idx;
  logic [IDX_W-1:0] scan_idx;
  logic             granted_valid;

  // Scan starts at rr_ptr so the consumer after the last grant has priority.
  always_comb begin
    arb_found = 1'b0;
    arb_read  = 1'b0;
    arb_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      scan_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_CONSUMERS);
      if (!arb_found && (consumer_read_valid[scan_idx] || consumer_write_valid[scan_idx])) begin
        arb_found = 1'b1;
        arb_idx   = scan_idx;
        arb_read  = consumer_read_valid[scan_idx];
      end
    end
  end

  assign granted_valid = is_read_q ? consumer_read_valid[grant_q] : consumer_write_valid[grant_q];

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    is_read_d = is_read_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          grant_d   = arb_idx;
          is_read_d = arb_read;
          addr_d    = arb_read ? consumer_read_address[arb_idx*ADDR_BITS +: ADDR_BITS]
                               : consumer_write_address[arb_idx*ADDR_BITS +: ADDR_BITS];
          wdata_d   = consumer_write_data[arb_idx*DATA_BITS +: DATA_BITS];
          rr_ptr_d  = IDX_W'((int'(arb_idx) + 1) % NUM_CONSUMERS);
          state_d   = arb_read ? READ_WAITING : WRITE_WAITING;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      READ_WAITING, WRITE_WAITING: begin
        if ((state_q == READ_WAITING) ? mem_read_ready : mem_write_ready) begin
          if (state_q == READ_WAITING) rdata_d[grant_q] = mem_read_data;
          state_d = RELAYING;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        // Abandon the access; the request stays pending and is re-arbitrated.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RELAYING: begin
        if (!granted_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      is_read_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      for (int i = 0; i < NUM_CONSUMERS; i++) rdata_q[i] <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      is_read_q <= is_read_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  logic [NUM_CONSUMERS-1:0] grant_onehot;
  assign grant_onehot = NUM_CONSUMERS'(1) << grant_q;

  // Memory-side address/data are zeroed while the matching valid is low.
  assign mem_read_valid    = (state_q == READ_WAITING);
  assign mem_write_valid   = (state_q == WRITE_WAITING);
  assign mem_read_address  = mem_read_valid  ? addr_q  : '0;
  assign mem_write_address = mem_write_valid ? addr_q  : '0;
  assign mem_write_data    = mem_write_valid ? wdata_q : '0;

  assign consumer_read_ready  = (state_q == RELAYING &&  is_read_q) ? grant_onehot : '0;
  assign consumer_write_ready = (state_q == RELAYING && !is_read_q) ? grant_onehot : '0;

  for (genvar i = 0; i < NUM_CONSUMERS; i++) begin : g_rdata
    assign consumer_read_data[i*DATA_BITS +: DATA_BITS] = rdata_q[i];
  end

`ifdef MEM_ARB_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter (4 consumers, 8-bit address/data),
// plus a read-completion scoreboard and an optional watchdog sequence.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic          clk;
  logic          reset;
  logic [N-1:0]  consumer_read_valid;
  logic [N*AW-1:0] consumer_read_address;
  logic [N-1:0]  consumer_read_ready;
  logic [N*DW-1:0] consumer_read_data;
  logic [N-1:0]  consumer_write_valid;
  logic [N*AW-1:0] consumer_write_address;
  logic [N*DW-1:0] consumer_write_data;
  logic [N-1:0]  consumer_write_ready;
  logic          mem_read_valid;
  logic [AW-1:0] mem_read_address;
  logic          mem_read_ready;
  logic [DW-1:0] mem_read_data;
  logic          mem_write_valid;
  logic [AW-1:0] mem_write_address;
  logic [DW-1:0] mem_write_data;
  logic          mem_write_ready;
  logic          timeout_err;

  mem_arbiter #(
    .NUM_CONSUMERS(N), .ADDR_BITS(AW), .DATA_BITS(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(consumer_read_valid),
    .consumer_read_address(consumer_read_address),
    .consumer_read_ready(consumer_read_ready),
    .consumer_read_data(consumer_read_data),
    .consumer_write_valid(consumer_write_valid),
    .consumer_write_address(consumer_write_address),
    .consumer_write_data(consumer_write_data),
    .consumer_write_ready(consumer_write_ready),
    .mem_read_valid(mem_read_valid),
    .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid),
    .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data),
    .mem_write_ready(mem_write_ready),
    .timeout_err(timeout_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed per-consumer addresses and data, packed c3..c0.
  localparam logic [31:0] RADDR = 32'h40301008;
  localparam logic [31:0] WADDR = 32'h60205070;
  localparam logic [31:0] WDATA = 32'h335C2211;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         rst;
    logic [3:0]   rv, wv;
    logic         mrr, mwr;
    logic [7:0]   mrd;
    logic         exp_mrv, exp_mwv;
    logic [7:0]   exp_raddr, exp_waddr, exp_wdata;
    logic [3:0]   exp_crr, exp_cwr;
    logic [31:0]  exp_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic [3:0] rv, input logic [3:0] wv,
                              input logic mrr, input logic mwr, input logic [7:0] mrd,
                              input logic mrv, input logic mwv, input logic [7:0] a,
                              input logic [7:0] wd, input logic [3:0] crr,
                              input logic [3:0] cwr, input logic [31:0] rdata);
    vec_t v;
    v.rst = rst; v.rv = rv; v.wv = wv; v.mrr = mrr; v.mwr = mwr; v.mrd = mrd;
    v.exp_mrv   = mrv;
    v.exp_mwv   = mwv;
    v.exp_raddr = mrv ? a : 8'h00;
    v.exp_waddr = mwv ? a : 8'h00;
    v.exp_wdata = mwv ? wd : 8'h00;
    v.exp_crr   = crr;
    v.exp_cwr   = cwr;
    v.exp_rdata = rdata;
    vecs.push_back(v);
  endfunction

  // ---------------- scoreboard: read completions {index, data} ----------------
  logic [9:0] exp_q[$];
  logic [N-1:0] prev_crr = '0;

  always @(negedge clk) begin
    check("one_mem_valid", {31'd0, mem_read_valid & mem_write_valid}, 32'd0);
    for (int i = 0; i < N; i++) begin
      if (consumer_read_ready[i] && !prev_crr[i]) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_read", 32'd1, 32'd0);
        end else begin
          check("sb_read_done", {22'd0, 2'(i), consumer_read_data[i*DW +: DW]},
                {22'd0, exp_q.pop_front()});
        end
      end
    end
    prev_crr = consumer_read_ready;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    consumer_read_valid    = '0;
    consumer_write_valid   = '0;
    consumer_read_address  = RADDR;
    consumer_write_address = WADDR;
    consumer_write_data    = WDATA;
    mem_read_ready  = 1'b0;
    mem_write_ready = 1'b0;
    mem_read_data   = '0;

    //   rst rv     wv     mrr mwr mrd    mrv mwv addr   wdata  crr    cwr    rdata
    add(1, 4'b0000,4'b0000,0,0,8'h00, 0,0,8'h00,8'h00,4'b0000,4'b0000,32'h00000000); // reset
    add(0, 4'b0010,4'b0000,0,0,8'h00, 1,0,8'h10,8'h00,4'b0000,4'b0000,32'h00000000); // c1 read grant
    add(0, 4'b0010,4'b0000,0,0,8'h00, 1,0,8'h10,8'h00,4'b0000,4'b0000,32'h00000000);
    add(0, 4'b0010,4'b0000,1,0,8'hAB, 0,0,8'h00,8'h00,4'b0010,4'b0000,32'h0000AB00);
    add(0, 4'b0010,4'b0000,0,0,8'h00, 0,0,8'h00,8'h00,4'b0010,4'b0000,32'h0000AB00);
    add(0, 4'b0000,4'b0000,0,0,8'h00, 0,0,8'h00,8'h00,4'b0000,4'b0000,32'h0000AB00);
    add(0, 4'b0000,4'b0100,0,0,8'h00, 0,1,8'h20,8'h5C,4'b0000,4'b0000,32'h0000AB00); // c2 write
    add(0, 4'b0000,4'b0100,0,1,8'h00, 0,0,8'h00,8'h00,4'b0000,4'b0100,32'h0000AB00);
    add(0, 4'b0000,4'b0000,0,0,8'h00, 0,0,8'h00,8'h00,4'b0000,4'b0000,32'h0000AB00);
    add(0, 4'b0000,4'b0000,1,0,8'hFF, 0,0,8'h00,8'h00,4'b0000,4'b0000,32'h0000AB00); // stray ready
    add(1, 4'b0000,4'b0000,0,0,8'h00, 0,0,8'h00,8'h00,4'b0000,4'b0000,32'h00000000); // reset
    add(0, 4'b1111,4'b0000,0,0,8'h00, 1,0,8'h08,8'h00,4'b0000,4'b0000,32'h00000000); // all read: c0
    add(0, 4'b1111,4'b0000,1,0,8'hA0, 0,0,8'h00,8'h00,4'b0001,4'b0000,32'h000000A0);
    add(0, 4'b1110,4'b0000,0,0,8'h00, 0,0,8'h00,8'h00,4'b0000,4'b0000,32'h000000A0);
    add(0, 4'b1110,4'b0000,0,0,8'h00, 1,0,8'h10,8'h00,4'b0000,4'b0000,32'h000000A0); // c1
    add(0, 4'b1111,4'b0000,1,0,8'hA1, 0,0,8'h00,8'h00,4'b0010,4'b0000,32'h0000A1A0); // c0 again
    add(0, 4'b1101,4'b0000,0,0,8'h00, 0,0,8'h00,8'h00,4'b0000,4'b0000,32'h0000A1A0);
    add(0, 4'b1101,4'b0000,0,0,8'h00, 1,0,8'h30,8'h00,4'b0000,4'b0000,32'h0000A1A0); // c2
    add(0, 4'b1101,4'b0000,1,0,8'hA2, 0,0,8'h00,8'h00,4'b0100,4'b0000,32'h00A2A1A0);
    add(0, 4'b1001,4'b0000,0,0,8'h00, 0,0,8'h00,8'h00,4'b0000,4'b0000,32'h00A2A1A0);
    add(0, 4'b1001,4'b0000,0,0,8'h00, 1,0,8'h40,8'h00,4'b0000,4'b0000,32'h00A2A1A0); // c3
    add(0, 4'b1001,4'b0000,1,0,8'hA3, 0,0,8'h00,8'h00,4'b1000,4'b0000,32'hA3A2A1A0);
    add(0, 4'b0001,4'b0000,0,0,8'h00, 0,0,8'h00,8'h00,4'b0000,4'b0000,32'hA3A2A1A0);
    add(0, 4'b0001,4'b0000,0,0,8'h00, 1,0,8'h08,8'h00,4'b0000,4'b0000,32'hA3A2A1A0); // c0 after c3
    add(0, 4'b0001,4'b0000,1,0,8'hB0, 0,0,8'h00,8'h00,4'b0001,4'b0000,32'hA3A2A1B0);
    add(0, 4'b0000,4'b0000,0,0,8'h00, 0,0,8'h00,8'h00,4'b0000,4'b0000,32'hA3A2A1B0);
    add(0, 4'b0001,4'b0001,0,0,8'h00, 1,0,8'h08,8'h00,4'b0000,4'b0000,32'hA3A2A1B0); // c0 rd+wr: read
    add(0, 4'b0001,4'b0001,0,1,8'h00, 1,0,8'h08,8'h00,4'b0000,4'b0000,32'hA3A2A1B0); // wr ready ignored
    add(0, 4'b0001,4'b0001,1,0,8'hC0, 0,0,8'h00,8'h00,4'b0001,4'b0000,32'hA3A2A1C0);
    add(0, 4'b0000,4'b0001,0,0,8'h00, 0,0,8'h00,8'h00,4'b0000,4'b0000,32'hA3A2A1C0);
    add(0, 4'b0000,4'b0001,0,0,8'h00, 0,1,8'h70,8'h11,4'b0000,4'b0000,32'hA3A2A1C0); // c0 write
    add(0, 4'b0000,4'b0001,0,1,8'h00, 0,0,8'h00,8'h00,4'b0000,4'b0001,32'hA3A2A1C0);
    add(0, 4'b0000,4'b0000,0,0,8'h00, 0,0,8'h00,8'h00,4'b0000,4'b0000,32'hA3A2A1C0);
    add(0, 4'b0100,4'b0000,0,0,8'h00, 1,0,8'h30,8'h00,4'b0000,4'b0000,32'hA3A2A1C0); // c2 read
    add(1, 4'b0100,4'b0000,0,0,8'h00, 0,0,8'h00,8'h00,4'b0000,4'b0000,32'h00000000); // mid reset
    add(0, 4'b0000,4'b0000,1,0,8'hEE, 0,0,8'h00,8'h00,4'b0000,4'b0000,32'h00000000); // late ready
    add(0, 4'b1010,4'b0000,0,0,8'h00, 1,0,8'h10,8'h00,4'b0000,4'b0000,32'h00000000); // rr back at 0
    add(0, 4'b1010,4'b0000,1,0,8'h5A, 0,0,8'h00,8'h00,4'b0010,4'b0000,32'h00005A00);
    add(0, 4'b1000,4'b0000,0,0,8'h00, 0,0,8'h00,8'h00,4'b0000,4'b0000,32'h00005A00);
    add(0, 4'b1000,4'b0000,0,0,8'h00, 1,0,8'h40,8'h00,4'b0000,4'b0000,32'h00005A00);
    add(0, 4'b1000,4'b0000,1,0,8'h77, 0,0,8'h00,8'h00,4'b1000,4'b0000,32'h77005A00);
    add(0, 4'b0000,4'b0000,0,0,8'h00, 0,0,8'h00,8'h00,4'b0000,4'b0000,32'h77005A00);

    exp_q = '{ {2'd1, 8'hAB}, {2'd0, 8'hA0}, {2'd1, 8'hA1}, {2'd2, 8'hA2}, {2'd3, 8'hA3},
               {2'd0, 8'hB0}, {2'd0, 8'hC0}, {2'd1, 8'h5A}, {2'd3, 8'h77} };
`ifdef MEM_ARB_TIMEOUT_EN
    exp_q.push_back({2'd0, 8'h99});
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      reset                = vecs[i].rst;
      consumer_read_valid  = vecs[i].rv;
      consumer_write_valid = vecs[i].wv;
      mem_read_ready       = vecs[i].mrr;
      mem_write_ready      = vecs[i].mwr;
      mem_read_data        = vecs[i].mrd;
      step();
      check($sformatf("v%0d_mem_read_valid", i),  {31'd0, mem_read_valid},  {31'd0, vecs[i].exp_mrv});
      check($sformatf("v%0d_mem_write_valid", i), {31'd0, mem_write_valid}, {31'd0, vecs[i].exp_mwv});
      check($sformatf("v%0d_mem_read_addr", i),   {24'd0, mem_read_address},  {24'd0, vecs[i].exp_raddr});
      check($sformatf("v%0d_mem_write_addr", i),  {24'd0, mem_write_address}, {24'd0, vecs[i].exp_waddr});
      check($sformatf("v%0d_mem_write_data", i),  {24'd0, mem_write_data},    {24'd0, vecs[i].exp_wdata});
      check($sformatf("v%0d_read_ready", i),      {28'd0, consumer_read_ready},  {28'd0, vecs[i].exp_crr});
      check($sformatf("v%0d_write_ready", i),     {28'd0, consumer_write_ready}, {28'd0, vecs[i].exp_cwr});
      check($sformatf("v%0d_read_data", i),       consumer_read_data, vecs[i].exp_rdata);
      check($sformatf("v%0d_timeout_err", i),     {31'd0, timeout_err}, 32'd0);
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // Unresponsive memory: valid stays up for TO waiting cycles, then retry.
    begin
      int hi;
      consumer_read_valid = 4'b0001;
      mem_read_ready      = 1'b0;
      step();
      check("to_grant_valid", {31'd0, mem_read_valid}, 32'd1);
      check("to_grant_addr", {24'd0, mem_read_address}, 32'h08);
      hi = 1;
      for (int k = 0; k < 20 && mem_read_valid; k++) begin
        step();
        if (mem_read_valid) hi++;
      end
      check("to_valid_cycles", hi, TO);
      check("to_err_set", {31'd0, timeout_err}, 32'd1);
      check("to_no_ready", {28'd0, consumer_read_ready}, 32'd0);
      step();
      check("to_reissue_valid", {31'd0, mem_read_valid}, 32'd1);
      check("to_reissue_addr", {24'd0, mem_read_address}, 32'h08);
      mem_read_ready = 1'b1;
      mem_read_data  = 8'h99;
      step();
      mem_read_ready = 1'b0;
      check("to_done_ready", {28'd0, consumer_read_ready}, 32'h1);
      consumer_read_valid = 4'b0000;
      step();
      check("to_idle_ready", {28'd0, consumer_read_ready}, 32'h0);
      check("to_err_sticky", {31'd0, timeout_err}, 32'd1);
    end
`endif

    step();
    check("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one external memory channel (read + write) between NUM_CONSUMERS requesters, typically the per-thread LSUs of a core.
- Round-robin grant; one transaction outstanding at a time.
- Valid/ready handshakes on both sides.
- Sits between the core LSUs and the global data-memory port.

Parameters:
- NUM_CONSUMERS, 4, number of requesters (≥1)
- ADDR_BITS, 8, memory address width
- DATA_BITS, 8, memory data width
- TIMEOUT_CYCLES, 255, wait-cycle limit; used only with MEM_ARB_TIMEOUT_EN

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- consumer_read_valid  input  NUM_CONSUMERS  per-consumer read request
- consumer_read_address  input  NUM_CONSUMERS*ADDR_BITS  read addresses; consumer i in bits [i*ADDR_BITS +: ADDR_BITS]
- consumer_read_ready  output  NUM_CONSUMERS  read complete / data valid
- consumer_read_data  output  NUM_CONSUMERS*DATA_BITS  returned read data, packed like the addresses
- consumer_write_valid  input  NUM_CONSUMERS  per-consumer write request
- consumer_write_address  input  NUM_CONSUMERS*ADDR_BITS  write addresses
- consumer_write_data  input  NUM_CONSUMERS*DATA_BITS  write data
- consumer_write_ready  output  NUM_CONSUMERS  write complete
- mem_read_valid  output  1  memory read request
- mem_read_address  output  ADDR_BITS  memory read address
- mem_read_ready  input  1  memory read done; data valid this cycle
- mem_read_data  input  DATA_BITS  memory read data
- mem_write_valid  output  1  memory write request
- mem_write_address  output  ADDR_BITS  memory write address
- mem_write_data  output  DATA_BITS  memory write data
- mem_write_ready  input  1  memory write done
- timeout_err  output  1  sticky timeout flag; constant 0 unless MEM_ARB_TIMEOUT_EN

Behaviour:
- Reset: all outputs 0; state IDLE; rr_ptr=0; grant index=0. Applies on any edge with reset=1, including mid-transaction. An in-flight memory request is abandoned; the memory side must tolerate this.
- States: IDLE, READ_WAITING, WRITE_WAITING, RELAYING.
- IDLE, arbitration:
  - Scan i = rr_ptr, rr_ptr+1, … mod NUM_CONSUMERS.
  - Grant the first i with read_valid or write_valid. If both are set on the same consumer, the read wins; the write is served on a later grant.
  - On grant: latch index g, kind, address and write data. Assert mem_read_valid or mem_write_valid, with address/data, at the next edge. Go to READ_WAITING or WRITE_WAITING. Set rr_ptr = (g+1) mod NUM_CONSUMERS.
  - No request: stay in IDLE, rr_ptr unchanged.
- READ_WAITING:
  - Hold mem_read_valid/address stable.
  - On mem_read_ready=1: next edge drives mem_read_valid=0, consumer_read_data[g]=mem_read_data, consumer_read_ready[g]=1; go to RELAYING.
- WRITE_WAITING: same, using mem_write_ready and consumer_write_ready[g]; no data capture.
- RELAYING:
  - Hold ready[g] until the granted consumer's valid of the granted kind is 0.
  - Next edge: ready[g]=0, go to IDLE.
  - Consumers must drop valid after seeing ready and must not change address/data while valid is asserted.
- Latency:
  - Request visible in IDLE at edge t → mem valid high after edge t+1.
  - mem ready sampled at edge k → consumer ready high after k+1.
  - Consumer valid low sampled at j → ready low and IDLE after j+1; the next grant is issued from that IDLE cycle.
  - Minimum 4 cycles per transaction with a 1-cycle memory.
- Data hold: consumer_read_data[i] keeps its value until consumer i's next read completes.
- Ignored inputs:
  - mem_*_ready outside the matching WAITING state.
  - Valids of non-granted consumers during a transaction. They stay pending.
- NUM_CONSUMERS=1: degenerates to a pass-through sequencer; rr_ptr stays 0.
- At most one of mem_read_valid / mem_write_valid is high at any time.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter (≥ clog2(TIMEOUT_CYCLES+1) bits) clears on entry to either WAITING state and increments each WAITING cycle.
  - If the count reaches TIMEOUT_CYCLES with no mem ready: next edge drops mem valid, sets timeout_err=1 (sticky until reset), drives no consumer ready, and returns to IDLE.
  - The timed-out consumer's request remains pending and is re-arbitrated.
- Undefined: no counter; timeout_err tied 0; WAITING states wait indefinitely.

Test Plan:
- Single read: c1 reads addr 0x10, memory returns 0xAB after 2 cycles → mem_read_address=0x10; consumer_read_data[1]=0xAB with ready[1]=1; ready drops one cycle after c1 drops valid.
- Single write: c2 writes 0x5C to 0x20 → mem_write_valid with addr 0x20, data 0x5C; write_ready[2] pulses through RELAYING; no read activity.
- Round-robin: all 4 consumers request reads simultaneously from reset → grants in order 0,1,2,3. Re-requesting c0 during c1's transaction is served after c3.
- Read/write same consumer: c0 asserts both → read served first, write on its next grant.
- Reset mid-transaction: reset in READ_WAITING → all outputs 0, IDLE, rr_ptr=0 next cycle. A late mem_read_ready does not set any consumer ready.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: memory never responds → mem_read_valid drops after 8 WAITING cycles; timeout_err=1 and stays 1; the request is re-issued.
